// File: rtl/frame_renderer.sv
// 640x480@60 VGA raster for the runner game: draws three ground lanes and the player
// sprite from per-frame snapshots, and emits a once-per-frame tick.
module frame_renderer #(
    parameter int unsigned PIX_DIV   = 4,
    parameter int unsigned PLAYER_X  = 20,
    parameter int unsigned PLAYER_SZ = 16,
    parameter int unsigned TOP_Y     = 112,
    parameter int unsigned MID_Y     = 232,
    parameter int unsigned BOT_Y     = 352
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [639:0] ground_top,
    input  logic [639:0] ground_middle,
    input  logic [639:0] ground_bottom,
    input  logic [8:0]   height,
    input  logic         is_dead,
    output logic [11:0]  rgb,
    output logic         hsync,
    output logic         vsync,
    output logic         frame_tick
);

    localparam int unsigned DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    logic [DW-1:0] div_cnt;
    logic [9:0]    h_cnt;
    logic [9:0]    v_cnt;
    logic          pix_en;
    logic          snap_pt;

    logic [639:0]  gt_s;
    logic [639:0]  gm_s;
    logic [639:0]  gb_s;
    logic [8:0]    h_s;
    logic          dead_s;

    logic          visible;
    logic          in_player;
    logic          on_ground;
    logic [9:0]    col;
    logic [11:0]   pix_rgb;
    logic          hsync_n;
    logic          vsync_n;

    assign pix_en  = (div_cnt == DW'(PIX_DIV - 1));
    assign snap_pt = pix_en && (h_cnt == 10'd0) && (v_cnt == 10'd480);

    always_comb begin
        visible   = (h_cnt < 10'd640) && (v_cnt < 10'd480);
        // Column index is forced to 0 in blanking so the lane select never leaves 0..639.
        col       = visible ? h_cnt : 10'd0;
        in_player = (h_cnt >= 10'(PLAYER_X)) && (h_cnt < 10'(PLAYER_X + PLAYER_SZ)) &&
                    (v_cnt >= {1'b0, h_s}) && (v_cnt < ({1'b0, h_s} + 10'(PLAYER_SZ)));
        on_ground = ((v_cnt >= 10'(TOP_Y)) && (v_cnt < 10'(TOP_Y + 8)) && gt_s[col]) ||
                    ((v_cnt >= 10'(MID_Y)) && (v_cnt < 10'(MID_Y + 8)) && gm_s[col]) ||
                    ((v_cnt >= 10'(BOT_Y)) && (v_cnt < 10'(BOT_Y + 8)) && gb_s[col]);
        pix_rgb   = '0;
        if (visible) begin
            if (in_player)      pix_rgb = 12'hFF0;
            else if (on_ground) pix_rgb = 12'h0F0;
            else if (dead_s)    pix_rgb = 12'h400;
            else                pix_rgb = 12'h000;
        end
        hsync_n = !((h_cnt >= 10'd656) && (h_cnt < 10'd752));
        vsync_n = !((v_cnt >= 10'd490) && (v_cnt < 10'd492));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt    <= '0;
            h_cnt      <= '0;
            v_cnt      <= '0;
            rgb        <= '0;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            frame_tick <= 1'b0;
            gt_s       <= '0;
            gm_s       <= '0;
            gb_s       <= '0;
            h_s        <= '0;
            dead_s     <= 1'b0;
        end else begin
            frame_tick <= snap_pt;
            if (pix_en) begin
                div_cnt <= '0;
                rgb     <= pix_rgb;
                hsync   <= hsync_n;
                vsync   <= vsync_n;
                if (h_cnt == 10'd799) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == 10'd524) ? 10'd0 : v_cnt + 10'd1;
                end else begin
                    h_cnt <= h_cnt + 10'd1;
                end
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
            if (snap_pt) begin
                gt_s   <= ground_top;
                gm_s   <= ground_middle;
                gb_s   <= ground_bottom;
                h_s    <= height;
                dead_s <= is_dead;
            end
        end
    end

endmodule

// File: tb/tb_frame_renderer.sv
// Scoreboard bench for frame_renderer: a raster-position model predicts every pixel,
// sync level and frame_tick; a separate monitor compares them as the DUT emits pixels.
module tb_frame_renderer;

    localparam int unsigned P     = 2;
    localparam longint      FRAME = 800 * 525 * P;
    // Tick is registered: it appears one clk after the pix_en at (0,480).
    localparam longint      FIRST_TICK = 480 * 800 * P + P;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [639:0] ground_top = '0;
    logic [639:0] ground_middle = '0;
    logic [639:0] ground_bottom = '0;
    logic [8:0]   height = '0;
    logic         is_dead = 1'b0;
    logic [11:0]  rgb;
    logic         hsync;
    logic         vsync;
    logic         frame_tick;

    always #5 clk = ~clk;

    frame_renderer #(.PIX_DIV(P)) dut (
        .clk(clk), .reset(reset),
        .ground_top(ground_top), .ground_middle(ground_middle), .ground_bottom(ground_bottom),
        .height(height), .is_dead(is_dead),
        .rgb(rgb), .hsync(hsync), .vsync(vsync), .frame_tick(frame_tick)
    );

    int tests = 0;
    int fails = 0;

    longint t = 0;
    bit     running = 0;
    longint tick_due = -1;

    logic [639:0] m_gt = '0, m_gm = '0, m_gb = '0;
    int           m_h = 0;
    bit           m_dead = 0;

    typedef struct {
        int          x;
        int          y;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } exp_t;
    exp_t q[$];

    function automatic logic [11:0] ref_colour(int x, int y);
        if (x >= 640 || y >= 480) return 12'h000;
        if (x >= 20 && x < 36 && y >= m_h && y < m_h + 16) return 12'hFF0;
        if ((y >= 112 && y < 120 && m_gt[x]) ||
            (y >= 232 && y < 240 && m_gm[x]) ||
            (y >= 352 && y < 360 && m_gb[x])) return 12'h0F0;
        return m_dead ? 12'h400 : 12'h000;
    endfunction

    function automatic logic [639:0] rand_lane();
        logic [639:0] r;
        for (int i = 0; i < 20; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic check(input string name, input longint got, input longint want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0d",
                     name, got, got, want, want, t);
        end
    endtask

    // Clocks elapsed since the reset state was entered.
    always @(posedge clk) begin
        if (reset) begin
            t = 0;
            running = 1;
        end else if (running) begin
            t = t + 1;
        end
    end

    // Producer: on each pixel-enable clock, predict what the DUT will register.
    always @(negedge clk) begin
        if (running) begin
            if (reset) begin
                q.delete();
                m_gt = '0; m_gm = '0; m_gb = '0; m_h = 0; m_dead = 0;
                tick_due = -1;
            end else if (t % P == P - 1) begin
                longint p;
                exp_t   e;
                p    = t / P;
                e.x  = int'(p % 800);
                e.y  = int'((p / 800) % 525);
                e.rgb = ref_colour(e.x, e.y);
                e.hs = !(e.x >= 656 && e.x < 752);
                e.vs = !(e.y >= 490 && e.y < 492);
                q.push_back(e);
                if (e.x == 0 && e.y == 480) begin
                    m_gt = ground_top; m_gm = ground_middle; m_gb = ground_bottom;
                    m_h = int'(height); m_dead = is_dead;
                    tick_due = t + 1;
                end
            end
        end
    end

    // Monitor: compares each newly registered pixel and the tick level.
    always @(negedge clk) begin
        if (running && !reset) begin
            if (t > 0 && t % P == 0) begin
                if (q.size() == 0) begin
                    check("pixel_queue_empty", 0, 1);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    tests++;
                    if (rgb !== e.rgb || hsync !== e.hs || vsync !== e.vs) begin
                        fails++;
                        $display("FAIL pixel(%0d,%0d): got rgb=%h hs=%b vs=%b, expected rgb=%h hs=%b vs=%b",
                                 e.x, e.y, rgb, hsync, vsync, e.rgb, e.hs, e.vs);
                    end
                end
            end
            check("frame_tick_level", longint'(frame_tick), longint'(t == tick_due));
        end
    end

    task automatic wait_tick(output longint at);
        at = -1;
        for (longint n = 0; n < FRAME + 100; n++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) begin
                at = t;
                break;
            end
        end
        if (at < 0) check("frame_tick_timeout", 0, 1);
    endtask

    task automatic step_clk(input longint n);
        for (longint i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    initial begin
        longint t1, t2, t3, t4;

        repeat (3) @(posedge clk);
        #1;
        check("reset_rgb", longint'(rgb), 0);
        check("reset_hsync", longint'(hsync), 1);
        check("reset_vsync", longint'(vsync), 1);
        check("reset_tick", longint'(frame_tick), 0);

        // Frame 1: full top lane, player at the top edge.
        ground_top = '1;
        ground_middle = '0;
        ground_bottom = '0;
        height = 9'd0;
        reset = 1'b0;

        wait_tick(t1);
        check("first_tick_after_reset", t1, FIRST_TICK);

        // Change inputs around v=100 of the displayed frame: must only show after tick 2.
        @(posedge clk); #1;
        step_clk((45 + 100) * 800 * P);
        ground_top = rand_lane();
        ground_middle = rand_lane();
        ground_bottom = rand_lane();
        height = 9'd470;
        is_dead = 1'b1;

        wait_tick(t2);
        check("tick_interval_1", t2 - t1, FRAME);

        @(posedge clk); #1;
        ground_top = rand_lane();
        ground_middle = rand_lane();
        ground_bottom = rand_lane();
        height = 9'($urandom_range(0, 479));
        is_dead = 1'b0;

        wait_tick(t3);
        check("tick_interval_2", t3 - t2, FRAME);

        // Reset for one clk around v=300 of the next frame.
        @(posedge clk); #1;
        ground_middle = rand_lane();
        height = 9'($urandom_range(0, 479));
        step_clk((45 + 300) * 800 * P);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midreset_rgb", longint'(rgb), 0);
        check("midreset_hsync", longint'(hsync), 1);
        check("midreset_vsync", longint'(vsync), 1);
        check("midreset_tick", longint'(frame_tick), 0);

        wait_tick(t4);
        check("first_tick_after_midreset", t4, FIRST_TICK);

        step_clk(20 * 800 * P);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
